// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_stage_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    KILL = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: flush beats stall, stall holds, otherwise load a word or a bubble.
module if_id_reg
  import fetch_stage_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            flush,
  input  logic            load_valid,
  input  logic [XLEN-1:0] load_instr,
  input  logic [XLEN-1:0] load_pc,
  output logic [XLEN-1:0] instr_d,
  output logic [XLEN-1:0] pc_d,
  output logic [XLEN-1:0] pc_plus4_d,
  output logic            valid_d
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_d    <= NOP_INSTR;
      pc_d       <= '0;
      pc_plus4_d <= '0;
      valid_d    <= 1'b0;
    end else if (flush) begin
      instr_d <= NOP_INSTR;
      valid_d <= 1'b0;
    end else if (!stall) begin
      if (load_valid) begin
        instr_d    <= load_instr;
        pc_d       <= load_pc;
        pc_plus4_d <= load_pc + 32'd4;
        valid_d    <= 1'b1;
      end else begin
        instr_d <= NOP_INSTR;
        valid_d <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, single-outstanding memory FSM and one-entry fetch buffer.
// Optional FETCH_PERF_CNT_EN adds perf_fetched / perf_bubbles counters.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall_f,
  input  logic            stall_d,
  input  logic            flush_d,
  input  logic            pc_src_e,
  input  logic [XLEN-1:0] pc_target_e,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] instr_d,
  output logic [XLEN-1:0] pc_d,
  output logic [XLEN-1:0] pc_plus4_d,
  output logic            valid_d
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [XLEN-1:0] perf_fetched,
  output logic [XLEN-1:0] perf_bubbles
`endif
);

  fetch_state_t    state_reg, state_next;
  logic [XLEN-1:0] pc_f_reg;
  logic [XLEN-1:0] req_pc_reg;
  logic            buf_valid_reg;
  logic [XLEN-1:0] buf_instr_reg;
  logic [XLEN-1:0] buf_pc_reg;

  logic            can_req;
  logic            fire;
  logic            accept;
  logic            load_valid;
  logic [XLEN-1:0] load_instr;
  logic [XLEN-1:0] load_pc;

  // A new request is only safe if the response will have somewhere to land.
  assign can_req   = !stall_f && (!buf_valid_reg || !stall_d || flush_d);
  assign imem_req  = (state_reg == REQ) && can_req;
  assign imem_addr = pc_f_reg;
  assign fire      = imem_req && imem_gnt;
  assign accept    = (state_reg == WAIT) && imem_rvalid && !pc_src_e;

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE: state_next = REQ;
      REQ:  if (fire) state_next = pc_src_e ? KILL : WAIT;
      // A response coinciding with a redirect is dropped here, so nothing is left to kill.
      WAIT: if (imem_rvalid) state_next = REQ;
            else if (pc_src_e) state_next = KILL;
      KILL: if (imem_rvalid) state_next = REQ;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      pc_f_reg   <= RESET_VECTOR;
      req_pc_reg <= RESET_VECTOR;
    end else begin
      state_reg <= state_next;
      if (pc_src_e) begin
        pc_f_reg <= pc_target_e;
      end else if (fire) begin
        pc_f_reg <= pc_f_reg + 32'd4;
      end
      if (fire) begin
        req_pc_reg <= pc_f_reg;
      end
    end
  end

  // The buffer only fills while IF/ID is stalled; an unstalled cycle always empties it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_valid_reg <= 1'b0;
      buf_instr_reg <= NOP_INSTR;
      buf_pc_reg    <= '0;
    end else if (flush_d) begin
      buf_valid_reg <= 1'b0;
    end else if (stall_d) begin
      if (accept) begin
        buf_valid_reg <= 1'b1;
        buf_instr_reg <= imem_rdata;
        buf_pc_reg    <= req_pc_reg;
      end
    end else begin
      buf_valid_reg <= 1'b0;
    end
  end

  assign load_valid = buf_valid_reg || accept;
  assign load_instr = buf_valid_reg ? buf_instr_reg : imem_rdata;
  assign load_pc    = buf_valid_reg ? buf_pc_reg : req_pc_reg;

  if_id_reg u_if_id_reg (
    .clk        (clk),
    .rst_n      (rst_n),
    .stall      (stall_d),
    .flush      (flush_d),
    .load_valid (load_valid),
    .load_instr (load_instr),
    .load_pc    (load_pc),
    .instr_d    (instr_d),
    .pc_d       (pc_d),
    .pc_plus4_d (pc_plus4_d),
    .valid_d    (valid_d)
  );

`ifdef FETCH_PERF_CNT_EN
  logic [XLEN-1:0] perf_fetched_reg;
  logic [XLEN-1:0] perf_bubbles_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched_reg <= '0;
      perf_bubbles_reg <= '0;
    end else begin
      if (!flush_d && !stall_d && load_valid) begin
        perf_fetched_reg <= perf_fetched_reg + 32'd1;
      end
      if (flush_d || (!stall_d && !load_valid)) begin
        perf_bubbles_reg <= perf_bubbles_reg + 32'd1;
      end
    end
  end

  assign perf_fetched = perf_fetched_reg;
  assign perf_bubbles = perf_bubbles_reg;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: a memory model pushes expected IF/ID words, a monitor pops them.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall_f, stall_d, flush_d, pc_src_e;
  logic [31:0] pc_target_e;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic [31:0] instr_d, pc_d, pc_plus4_d;
  logic        valid_d;

  // second instance for the wrap-around reset vector
  logic        imem_req2, imem_gnt2, imem_rvalid2, valid_d2;
  logic [31:0] imem_addr2, instr_d2, pc_d2, pc_plus4_d2;
  logic [31:0] log2 [4];
  int          n2 = 0;
  logic        g2_prev;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched, perf_bubbles, perf_fetched2, perf_bubbles2;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  exp_t        exp_q [$];
  logic [31:0] model_pc;
  logic        gnt_en;
  int          lat;
  logic        pend, pend_kill;
  int          pend_cnt;
  logic [31:0] pend_addr, pend_pc;
  logic [31:0] glog [64];
  int          n_log;
  logic [31:0] last_instr;
  logic        last_valid;

  always #5 clk = ~clk;

  fetch_stage #(.RESET_VECTOR(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n), .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d),
    .pc_src_e(pc_src_e), .pc_target_e(pc_target_e),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr_d(instr_d), .pc_d(pc_d), .pc_plus4_d(pc_plus4_d), .valid_d(valid_d)
`ifdef FETCH_PERF_CNT_EN
    , .perf_fetched(perf_fetched), .perf_bubbles(perf_bubbles)
`endif
  );

  fetch_stage #(.RESET_VECTOR(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .stall_f(1'b0), .stall_d(1'b0), .flush_d(1'b0),
    .pc_src_e(1'b0), .pc_target_e(32'h0),
    .imem_req(imem_req2), .imem_addr(imem_addr2), .imem_gnt(imem_gnt2),
    .imem_rvalid(imem_rvalid2), .imem_rdata(32'h0),
    .instr_d(instr_d2), .pc_d(pc_d2), .pc_plus4_d(pc_plus4_d2), .valid_d(valid_d2)
`ifdef FETCH_PERF_CNT_EN
    , .perf_fetched(perf_fetched2), .perf_bubbles(perf_bubbles2)
`endif
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // memory model: decisions made on the falling edge, consumed at the next rising edge
  always @(negedge clk) begin
    if (!rst_n) begin
      imem_gnt    = 1'b0;
      imem_rvalid = 1'b0;
      if (pend) pend_kill = 1'b1;
      exp_q.delete();
      model_pc = 32'h0;
    end else begin
      logic granted;
      imem_rvalid = 1'b0;
      if (pend) begin
        if (pend_cnt == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata  = mem_word(pend_addr);
          pend        = 1'b0;
          if (!(pend_kill || pc_src_e || flush_d)) exp_q.push_back('{pend_pc, mem_word(pend_pc)});
        end else begin
          pend_cnt--;
          if (pc_src_e) pend_kill = 1'b1;
        end
      end
      imem_gnt = gnt_en && !pend;
      granted  = imem_req && imem_gnt;
      if (granted) begin
        check_eq("imem_addr", imem_addr, model_pc);
        if (n_log < 64) glog[n_log] = imem_addr;
        n_log++;
        pend      = 1'b1;
        pend_cnt  = lat;
        pend_addr = imem_addr;
        pend_pc   = model_pc;
        pend_kill = pc_src_e;
      end
      if (pc_src_e) model_pc = pc_target_e;
      else if (granted) model_pc = model_pc + 32'd4;
    end
  end

  // responder for the wrap-vector instance: always grants, answers next cycle
  always @(negedge clk) begin
    if (!rst_n) begin
      imem_gnt2    = 1'b0;
      imem_rvalid2 = 1'b0;
      g2_prev      = 1'b0;
    end else begin
      imem_rvalid2 = g2_prev;
      if (imem_req2 && n2 < 4) begin
        log2[n2] = imem_addr2;
        n2++;
      end
      g2_prev   = imem_req2;
      imem_gnt2 = 1'b1;
    end
  end

  // IF/ID monitor
  always @(posedge clk) begin
    logic ld, fl, rs;
    exp_t e;
    rs = rst_n;
    ld = rst_n && !stall_d && !flush_d;
    fl = rst_n && flush_d;
    #1;
    if (!rs) begin
      last_instr = NOP;
      last_valid = 1'b0;
    end else if (fl) begin
      check_eq("flush_valid", {31'b0, valid_d}, 32'd0);
      check_eq("flush_instr", instr_d, NOP);
      last_instr = NOP;
      last_valid = 1'b0;
    end else if (ld) begin
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_eq("load_valid", {31'b0, valid_d}, 32'd1);
        check_eq("load_instr", instr_d, e.instr);
        check_eq("load_pc", pc_d, e.pc);
        check_eq("load_pc4", pc_plus4_d, e.pc + 32'd4);
        last_instr = e.instr;
        last_valid = 1'b1;
      end else begin
        check_eq("bubble_valid", {31'b0, valid_d}, 32'd0);
        check_eq("bubble_instr", instr_d, NOP);
        last_instr = NOP;
        last_valid = 1'b0;
      end
    end else begin
      check_eq("hold_instr", instr_d, last_instr);
      check_eq("hold_valid", {31'b0, valid_d}, {31'b0, last_valid});
    end
  end

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_req"}, {31'b0, imem_req}, 32'd0);
    check_eq({tag, "_addr"}, imem_addr, 32'h0);
    check_eq({tag, "_instr"}, instr_d, NOP);
    check_eq({tag, "_pc"}, pc_d, 32'h0);
    check_eq({tag, "_pc4"}, pc_plus4_d, 32'h0);
    check_eq({tag, "_valid"}, {31'b0, valid_d}, 32'd0);
  endtask

  task automatic wait_pend(input string tag);
    int k;
    for (k = 0; k < 20; k++) begin
      tick();
      if (pend) break;
    end
    if (k == 20) check_eq({tag, "_timeout"}, 32'd1, 32'd0);
  endtask

  initial begin
    int mark;
    int k;
    rst_n = 1'b0; stall_f = 1'b0; stall_d = 1'b0; flush_d = 1'b0;
    pc_src_e = 1'b0; pc_target_e = 32'h0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    gnt_en = 1'b1; lat = 0; pend = 1'b0; pend_kill = 1'b0; pend_cnt = 0;
    pend_addr = 32'h0; pend_pc = 32'h0; n_log = 0; model_pc = 32'h0;
    last_instr = NOP; last_valid = 1'b0;

    repeat (2) tick();
    check_reset_outputs("reset");
    rst_n = 1'b1;
    repeat (12) tick();
    check_eq("first_addr0", glog[0], 32'h0);
    check_eq("first_addr1", glog[1], 32'h4);
    check_eq("first_addr2", glog[2], 32'h8);
    check_eq("wrap_addr0", log2[0], 32'hFFFF_FFFC);
    check_eq("wrap_addr1", log2[1], 32'h0000_0000);

    // IF/ID stalled while responses keep arriving
    stall_d = 1'b1;
    repeat (3) tick();
    stall_d = 1'b0;
    repeat (6) tick();

    // redirect while a response is outstanding
    lat = 2;
    wait_pend("redir");
    pc_src_e = 1'b1;
    pc_target_e = 32'h0000_0100;
    mark = n_log;
    tick();
    pc_src_e = 1'b0;
    for (k = 0; k < 20 && n_log <= mark; k++) tick();
    check_eq("redirect_addr", glog[mark], 32'h0000_0100);
    lat = 0;
    repeat (8) tick();

    // stall and flush together
    gnt_en = 1'b0;
    repeat (8) tick();
    stall_d = 1'b1;
    flush_d = 1'b1;
    tick();
    check_eq("stall_flush_valid", {31'b0, valid_d}, 32'd0);
    check_eq("stall_flush_instr", instr_d, NOP);
    stall_d = 1'b0;
    flush_d = 1'b0;
    gnt_en = 1'b1;
    repeat (6) tick();

    // reset while waiting on memory; the late response must be ignored
    lat = 3;
    wait_pend("rst_wait");
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    repeat (2) tick();
    rst_n = 1'b1;
    lat = 0;
    repeat (20) tick();

    gnt_en = 1'b0;
    repeat (10) tick();
    check_eq("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
